// File: rtl/mdio_responder.sv
// mdio_responder: Clause-22 MDIO PHY-side frame decoder driving a 32x16 register port.
module mdio_responder #(
  parameter logic [4:0] PHY_ADDR = 5'd1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MDC,
  input  logic        MDIO_IN,
  output logic        MDIO_OUT,
  output logic        MDIO_OE,
  output logic [4:0]  REG_ADDR,
  output logic [15:0] WR_DATA,
  output logic        WR_STB,
  output logic        RD_STB,
  input  logic [15:0] RD_DATA,
  output logic        BUSY
);
  typedef enum logic [2:0] {IDLE, ST1, HDR, SKIP, WTA, WDAT, RTA, RDAT} state_t;
  state_t state, state_n;
  logic [4:0] cnt, cnt_n, reg_n;
  logic [15:0] sh, sh_n, wd_n;
  logic mdc_q, out_n, oe_n, wr_n, rd_n;
  logic rise, fall, last;
  logic [11:0] hdr;
  assign rise = MDC & ~mdc_q;
  assign fall = ~MDC & mdc_q;
  assign hdr = {sh[10:0], MDIO_IN};
  assign last = cnt == 5'd31;
  assign BUSY = state != IDLE;
  // cnt holds the number of rises consumed in the current frame
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sh_n = sh;
    out_n = MDIO_OUT;
    oe_n = MDIO_OE;
    reg_n = REG_ADDR;
    wd_n = WR_DATA;
    wr_n = 1'b0;
    rd_n = 1'b0;
    if (rise) begin
      cnt_n = cnt + 5'd1;
      case (state)
        IDLE: begin
          state_n = MDIO_IN ? IDLE : ST1;
          cnt_n = MDIO_IN ? 5'd0 : 5'd1;
        end
        ST1: begin
          state_n = MDIO_IN ? HDR : IDLE;
          cnt_n = MDIO_IN ? 5'd2 : 5'd0;
        end
        HDR: begin
          sh_n = {sh[14:0], MDIO_IN};
          if (cnt == 5'd13) begin
            reg_n = hdr[4:0];
            if (hdr[9:5] != PHY_ADDR || hdr[11] == hdr[10]) state_n = SKIP;
            else if (hdr[10]) state_n = WTA;
            else begin
              state_n = RTA;
              rd_n = 1'b1;
            end
          end
        end
        SKIP: if (last) begin
          state_n = IDLE;
          cnt_n = 5'd0;
        end
        WTA: state_n = cnt == 5'd15 ? WDAT : WTA;
        WDAT: begin
          sh_n = {sh[14:0], MDIO_IN};
          if (last) begin
            wd_n = {sh[14:0], MDIO_IN};
            wr_n = 1'b1;
            state_n = IDLE;
            cnt_n = 5'd0;
          end
        end
        RTA: state_n = RTA;
        RDAT: if (last) begin
          state_n = IDLE;
          cnt_n = 5'd0;
        end
        default: begin
          state_n = IDLE;
          cnt_n = 5'd0;
        end
      endcase
    end else if (fall) begin
      // TA2 fall loads read data; the fall after rise 32 (already IDLE) releases the line
      if (state == RTA && cnt == 5'd15) begin
        sh_n = RD_DATA;
        oe_n = 1'b1;
        out_n = 1'b0;
        state_n = RDAT;
      end else if (state == RDAT) begin
        out_n = sh[15];
        sh_n = {sh[14:0], 1'b0};
      end else if (state == IDLE) begin
        oe_n = 1'b0;
        out_n = 1'b0;
      end
    end
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      cnt <= 5'd0;
      sh <= 16'd0;
      mdc_q <= 1'b0;
      MDIO_OUT <= 1'b0;
      MDIO_OE <= 1'b0;
      REG_ADDR <= 5'd0;
      WR_DATA <= 16'd0;
      WR_STB <= 1'b0;
      RD_STB <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sh <= sh_n;
      mdc_q <= MDC;
      MDIO_OUT <= out_n;
      MDIO_OE <= oe_n;
      REG_ADDR <= reg_n;
      WR_DATA <= wd_n;
      WR_STB <= wr_n;
      RD_STB <= rd_n;
    end
  end
endmodule
